seq_scan_ctrl: RTL and testbench

//  Controller that sequences a serial Mealy pattern detector over a parallel data word.

---
 rtl/seq_scan_if.sv | 36 +++
 rtl/seq_scan_ctrl.sv | 119 +++++++++++
 tb/tb_seq_scan_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_scan_if.sv
// ---------------------------------------------------------------------------
// seq_scan_if : config handshake and scan control/result bundle for seq_scan_ctrl
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface seq_scan_if #(
  parameter int PAT_W  = 4,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
);
  logic                      cfg_valid;
  logic [PAT_W-1:0]          cfg_pattern;
  logic                      cfg_ready;
  logic                      start;
  logic [DATA_W-1:0]         data_in;
  logic                      abort;
  logic                      busy;
  logic                      match;
  logic [CNT_W-1:0]          match_count;
  logic                      hit;
  logic [$clog2(DATA_W)-1:0] first_idx;
  logic                      done;

  modport master (
    output cfg_valid, cfg_pattern, start, data_in, abort,
    input  cfg_ready, busy, match, match_count, hit, first_idx, done
  );

  modport slave (
    input  cfg_valid, cfg_pattern, start, data_in, abort,
    output cfg_ready, busy, match, match_count, hit, first_idx, done
  );
endinterface

`default_nettype wire

// File: rtl/seq_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seq_scan_ctrl : shifts a captured word MSB-first through a Mealy pattern
//                 detector, reporting match pulses, count and first-hit index
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_scan_ctrl #(
  parameter int PAT_W  = 4,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic        clk,
  input  logic        rst,
  seq_scan_if.slave   bus
);
  localparam int IDX_W  = $clog2(DATA_W);
  localparam int FILL_W = $clog2(PAT_W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [PAT_W-1:0]  pattern;
  logic [DATA_W-1:0] shift_reg;
  logic [PAT_W-2:0]  window;
  logic [FILL_W-1:0] fill;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  match_count;
  logic              hit;
  logic [IDX_W-1:0]  first_idx;

  logic              cur_bit;
  logic [PAT_W-1:0]  window_nxt;
  logic              match_w;

  // Window plus the bit under the head is the candidate compared this cycle.
  assign cur_bit    = shift_reg[DATA_W-1];
  assign window_nxt = {window, cur_bit};
  assign match_w    = (state == S_SCAN) && !bus.abort &&
                      (fill >= FILL_W'(PAT_W - 1)) && (window_nxt == pattern);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_SCAN;
      S_SCAN: begin
        if (bus.abort)                         state_nxt = S_IDLE;
        else if (idx == IDX_W'(DATA_W - 1))    state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cfg_ready   = (state == S_IDLE);
    bus.busy        = (state == S_SCAN);
    bus.done        = (state == S_DONE);
    bus.match       = match_w;
    bus.match_count = match_count;
    bus.hit         = hit;
    bus.first_idx   = first_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern     <= '0;
      shift_reg   <= '0;
      window      <= '0;
      fill        <= '0;
      idx         <= '0;
      match_count <= '0;
      hit         <= 1'b0;
      first_idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cfg_valid) pattern <= bus.cfg_pattern;
          if (bus.start) begin
            shift_reg   <= bus.data_in;
            window      <= '0;
            fill        <= '0;
            idx         <= '0;
            match_count <= '0;
            hit         <= 1'b0;
            first_idx   <= '0;
          end
        end
        S_SCAN: begin
          // An aborted cycle leaves every partial result untouched.
          if (!bus.abort) begin
            shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
            window    <= window_nxt[PAT_W-2:0];
            if (fill != FILL_W'(PAT_W)) fill <= fill + 1'b1;
            idx <= idx + 1'b1;
            if (match_w) begin
              if (match_count != '1) match_count <= match_count + 1'b1;
              if (!hit) begin
                hit       <= 1'b1;
                first_idx <= idx;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_seq_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_scan_ctrl : scoreboard bench for seq_scan_ctrl with a bit-list reference model
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_scan_ctrl;
  localparam int PAT_W  = 4;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 3;
  localparam int CMAX   = (1 << CNT_W) - 1;

  typedef struct {
    int cnt;
    int hit;
    int fidx;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  seq_scan_if #(.PAT_W(PAT_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  seq_scan_ctrl #(.PAT_W(PAT_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_idx[$];
  res_t exp_res[$];
  logic [PAT_W-1:0] mdl_pattern = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  // Bit i of the scan is data bit DATA_W-1-i; a match ending at i needs the
  // last PAT_W scanned bits to equal the pattern, newest bit at pattern[0].
  task automatic model_push(input logic [PAT_W-1:0] p, input logic [DATA_W-1:0] d,
                            input int limit, input bit full,
                            output int n, output int fidx);
    bit ok;
    n = 0;
    fidx = 0;
    for (int i = PAT_W - 1; i < limit; i++) begin
      ok = 1'b1;
      for (int k = 0; k < PAT_W; k++)
        if (d[DATA_W-1-(i-k)] != p[k]) ok = 1'b0;
      if (ok) begin
        if (n == 0) fidx = i;
        n++;
        exp_idx.push_back(i);
      end
    end
    if (full) exp_res.push_back('{sat(n), (n > 0) ? 1 : 0, fidx});
  endtask

  // Monitor: per-cycle match check against expected indices, result check on done.
  initial begin
    int   pos      = 0;
    int   scan_len = 0;
    bit   prev_done = 1'b0;
    bit   exp_m;
    res_t r;
    forever begin
      @(negedge clk);
      if (bus.busy) begin
        exp_m = (exp_idx.size() > 0) && (exp_idx[0] == pos);
        chk($sformatf("match_idx%0d", pos), int'(bus.match), int'(exp_m));
        if (exp_m) void'(exp_idx.pop_front());
        pos++;
        scan_len = pos;
      end else begin
        pos = 0;
        chk("match_idle", int'(bus.match), 0);
      end
      if (bus.done) begin
        chk("done_single", int'(prev_done), 0);
        if (exp_res.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          r = exp_res.pop_front();
          chk("done_count", int'(bus.match_count), r.cnt);
          chk("done_hit", int'(bus.hit), r.hit);
          chk("done_first_idx", int'(bus.first_idx), r.fidx);
          chk("done_latency", scan_len, DATA_W);
        end
      end
      prev_done = bus.done;
    end
  end

  task automatic clear_inputs();
    bus.cfg_valid = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
  endtask

  task automatic run_scan(input logic [PAT_W-1:0] p, input bit do_cfg, input bit same_cycle,
                          input logic [DATA_W-1:0] d, input int abort_at,
                          input int poke_at, input int rst_at);
    int n, fidx, limit;
    bit full;
    if (do_cfg && !same_cycle) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_pattern = p;
      @(posedge clk); #1;
      bus.cfg_valid = 1'b0;
    end
    if (do_cfg) mdl_pattern = p;
    bus.cfg_valid = do_cfg && same_cycle;
    bus.cfg_pattern = p;
    bus.start = 1'b1;
    bus.data_in = d;
    limit = (abort_at >= 0) ? abort_at : (rst_at >= 0) ? rst_at : DATA_W;
    full = (abort_at < 0) && (rst_at < 0);
    model_push(mdl_pattern, d, limit, full, n, fidx);
    @(posedge clk); #1;
    clear_inputs();
    chk("busy_after_start", int'(bus.busy), 1);
    for (int k = 0; k < DATA_W; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        clear_inputs();
      end
      if (k == poke_at) begin
        chk("cfg_ready_scan", int'(bus.cfg_ready), 0);
        bus.cfg_valid = 1'b1;
        bus.cfg_pattern = PAT_W'($urandom);
        bus.start = 1'b1;
        bus.data_in = DATA_W'($urandom);
      end
      if (k == abort_at) begin
        bus.abort = 1'b1;
        @(posedge clk); #1;
        clear_inputs();
        chk("abort_idle", int'(bus.cfg_ready), 1);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_count", int'(bus.match_count), sat(n));
        chk("abort_hit", int'(bus.hit), (n > 0) ? 1 : 0);
        chk("abort_first_idx", int'(bus.first_idx), fidx);
        return;
      end
      if (k == rst_at) begin
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_cfg_ready", int'(bus.cfg_ready), 1);
        chk("arst_match", int'(bus.match), 0);
        chk("arst_count", int'(bus.match_count), 0);
        chk("arst_hit", int'(bus.hit), 0);
        chk("arst_first_idx", int'(bus.first_idx), 0);
        chk("arst_done", int'(bus.done), 0);
        clear_inputs();
        mdl_pattern = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        return;
      end
    end
    // DONE cycle: start and cfg_valid must both be ignored here.
    @(posedge clk); #1;
    chk("done_cfg_ready", int'(bus.cfg_ready), 0);
    bus.start = 1'b1;
    bus.data_in = DATA_W'($urandom);
    bus.cfg_valid = 1'b1;
    bus.cfg_pattern = PAT_W'($urandom);
    @(posedge clk); #1;
    clear_inputs();
    chk("idle_cfg_ready", int'(bus.cfg_ready), 1);
    chk("idle_busy", int'(bus.busy), 0);
    chk("hold_count", int'(bus.match_count), sat(n));
    chk("hold_first_idx", int'(bus.first_idx), fidx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PAT_W-1:0]  p;
    logic [DATA_W-1:0] d, rep;
    int s, ab, pk;
    clear_inputs();
    bus.cfg_pattern = '0;
    bus.data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cfg_ready", int'(bus.cfg_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_count", int'(bus.match_count), 0);
    chk("rst_hit", int'(bus.hit), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_scan(4'b1011, 1'b1, 1'b0, 16'hB0B0, -1, -1, -1);
    run_scan(4'b1010, 1'b1, 1'b1, 16'hAAAA, -1, -1, -1);
    run_scan(4'b1111, 1'b1, 1'b0, 16'hFFFF, -1, -1, -1);
    run_scan(4'b1011, 1'b1, 1'b0, 16'hB0B0, 8, 5, -1);
    run_scan(4'b0000, 1'b0, 1'b0, 16'hB0B0, -1, 2, -1);
    run_scan(4'b1011, 1'b1, 1'b0, 16'hB0B0, -1, -1, 9);
    run_scan(4'b0000, 1'b0, 1'b0, 16'h0F00, -1, -1, -1);
    run_scan(4'b1011, 1'b1, 1'b1, 16'hB0B0, -1, -1, -1);

    for (int t = 0; t < 40; t++) begin
      p = PAT_W'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        rep = {(DATA_W/PAT_W){p}};
        s = $urandom_range(0, PAT_W - 1);
        d = (rep << s) | (rep >> (DATA_W - s));
      end else begin
        d = DATA_W'($urandom);
      end
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, DATA_W - 1)) : -1;
      pk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, DATA_W - 1)) : -1;
      run_scan(p, ($urandom_range(0, 4) != 0), $urandom_range(0, 1) == 1, d, ab, pk, -1);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("leftover_matches", exp_idx.size(), 0);
    chk("leftover_results", exp_res.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
